// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter in front of the snooping bus.
// Grants at most one coherence request per cycle and registers it as the
// totally ordered bus broadcast seen by every cache and the memory controller.
//
// Flat port encodings:
//   req_addr[i*XLEN +: XLEN]  address of CPU i
//   req_tx[i*2 +: 2]          request type of CPU i
//                             (0=IDLE, 1=GETS, 2=GETM, 3=PUTM)
//   bus_out                   {valid, source[SRC_W-1:0], addr[XLEN-1:0], bus_tx[1:0]}
module snoop_bus_arbiter #(
  parameter int NUM_CPUS = 4,
  parameter int XLEN     = 6,
  parameter int SRC_W    = $clog2(NUM_CPUS) + 1,
  parameter int CNT_W    = 16,
  localparam int PTR_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1,
  localparam int BUS_W   = 1 + SRC_W + XLEN + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CPUS-1:0]      req_valid,
  input  logic [NUM_CPUS*XLEN-1:0] req_addr,
  input  logic [NUM_CPUS*2-1:0]    req_tx,
  output logic [NUM_CPUS-1:0]      req_ready,
  input  logic                     bus_stall,
  output logic [BUS_W-1:0]         bus_out,
  output logic [CNT_W-1:0]         grant_cnt
);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_GETS = 2'd1,
    TX_GETM = 2'd2,
    TX_PUTM = 2'd3
  } bus_tx_e;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0]  addr;
    bus_tx_e          bus_tx;
  } bus_msg_t;

  bus_msg_t            bus_q, bus_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_CPUS-1:0] eligible;
  logic                found;
  logic [PTR_W-1:0]    win;
  logic                grant;

  // A request is eligible only if valid and carrying a real transaction.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      eligible[i] = req_valid[i] && (req_tx[i*2 +: 2] != TX_IDLE);
    end
  end

  // Round-robin search starting at rr_ptr with modulo wrap; first eligible wins.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CPUS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_CPUS) idx = idx - NUM_CPUS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  // Grant handshake; suppressed while stalled or held in reset.
  always_comb begin
    grant     = found && !bus_stall && !rst;
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  // Next broadcast, pointer and counter; idle bus and held state when no grant.
  always_comb begin
    bus_d    = '0;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (grant) begin
      bus_d.valid  = 1'b1;
      bus_d.source = SRC_W'(win);
      bus_d.addr   = req_addr[win*XLEN +: XLEN];
      bus_d.bus_tx = bus_tx_e'(req_tx[win*2 +: 2]);
      rr_ptr_d     = (32'(win) == NUM_CPUS - 1) ? '0 : win + 1'b1;
      cnt_d        = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      bus_q    <= bus_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus_out   = bus_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed testbench for snoop_bus_arbiter (NUM_CPUS=4, XLEN=6, SRC_W=3).
module tb_snoop_bus_arbiter;

  localparam logic [1:0] IDLE = 2'd0, GETS = 2'd1, GETM = 2'd2, PUTM = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_addr  = '0;
  logic [7:0]  req_tx    = '0;
  logic [3:0]  req_ready;
  logic        bus_stall = 1'b0;
  logic [11:0] bus_out;
  logic [15:0] grant_cnt;

  int total = 0;
  int bad   = 0;

  snoop_bus_arbiter #(.NUM_CPUS(4), .XLEN(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_tx(req_tx), .req_ready(req_ready), .bus_stall(bus_stall),
    .bus_out(bus_out), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] msg(input logic v, input logic [2:0] s,
                                      input logic [5:0] a, input logic [1:0] t);
    return {v, s, a, t};
  endfunction

  task automatic set_req(input int cpu, input logic v, input logic [5:0] a, input logic [1:0] t);
    req_valid[cpu]       = v;
    req_addr[cpu*6 +: 6] = a;
    req_tx[cpu*2 +: 2]   = t;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_tx    = '0;
    bus_stall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i), GETS);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b expected %b", req_ready, 4'b0000); end
    total++; if (bus_out !== 12'h000) begin bad++; $display("FAIL reset_bus: got %h expected %h", bus_out, 12'h000); end
    total++; if (grant_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", grant_cnt); end
    total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr_q); end
    @(posedge clk); #1;
    total++; if (bus_out !== 12'h000) begin bad++; $display("FAIL reset_bus_edge: got %h expected %h", bus_out, 12'h000); end
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 1'b1, 6'h2A, GETM);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0100); end
    @(posedge clk); #1;
    total++; if (bus_out !== msg(1'b1, 3'd2, 6'h2A, GETM)) begin bad++; $display("FAIL single_bus: got %h expected %h", bus_out, msg(1'b1, 3'd2, 6'h2A, GETM)); end
    total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt: got %0d expected 1", grant_cnt); end
    @(negedge clk);
    set_req(2, 1'b0, 6'h00, IDLE);
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_after: got %b expected %b", req_ready, 4'b0000); end
    @(posedge clk); #1;
    total++; if (bus_out !== 12'h000) begin bad++; $display("FAIL single_bus_drop: got %h expected %h", bus_out, 12'h000); end
    total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt_hold: got %0d expected 1", grant_cnt); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(6'h10 + i), GETS);
    for (int k = 0; k < 6; k++) begin
      #1;
      total++; if (req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % 4))); end
      @(posedge clk); #1;
      total++; if (bus_out !== msg(1'b1, 3'(k % 4), 6'(6'h10 + k % 4), GETS)) begin bad++; $display("FAIL rr_bus[%0d]: got %h expected %h", k, bus_out, msg(1'b1, 3'(k % 4), 6'(6'h10 + k % 4), GETS)); end
      total++; if (grant_cnt !== 16'(k + 1)) begin bad++; $display("FAIL rr_cnt[%0d]: got %0d expected %0d", k, grant_cnt, k + 1); end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_idle_filter();
    do_reset();
    set_req(0, 1'b1, 6'h3F, IDLE);
    set_req(1, 1'b1, 6'h05, PUTM);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL idle_ready: got %b expected %b", req_ready, 4'b0010); end
    @(posedge clk); #1;
    total++; if (bus_out !== msg(1'b1, 3'd1, 6'h05, PUTM)) begin bad++; $display("FAIL idle_bus: got %h expected %h", bus_out, msg(1'b1, 3'd1, 6'h05, PUTM)); end
    @(negedge clk);
    set_req(1, 1'b0, 6'h00, IDLE);
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_only_ready[%0d]: got %b expected %b", k, req_ready, 4'b0000); end
      @(posedge clk); #1;
      total++; if (bus_out !== 12'h000) begin bad++; $display("FAIL idle_only_bus[%0d]: got %h expected %h", k, bus_out, 12'h000); end
      @(negedge clk);
    end
    total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL idle_cnt: got %0d expected 1", grant_cnt); end
    clear_reqs();
  endtask

  task automatic test_stall();
    do_reset();
    set_req(3, 1'b1, 6'h33, GETS);
    bus_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready[%0d]: got %b expected %b", k, req_ready, 4'b0000); end
      @(posedge clk); #1;
      total++; if (bus_out !== 12'h000) begin bad++; $display("FAIL stall_bus[%0d]: got %h expected %h", k, bus_out, 12'h000); end
      total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL stall_ptr[%0d]: got %0d expected 0", k, dut.rr_ptr_q); end
      @(negedge clk);
    end
    bus_stall = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_release_ready: got %b expected %b", req_ready, 4'b1000); end
    @(posedge clk); #1;
    total++; if (bus_out !== msg(1'b1, 3'd3, 6'h33, GETS)) begin bad++; $display("FAIL stall_release_bus: got %h expected %h", bus_out, msg(1'b1, 3'd3, 6'h33, GETS)); end
    total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL stall_release_cnt: got %0d expected 1", grant_cnt); end
    total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL stall_wrap_ptr: got %0d expected 0", dut.rr_ptr_q); end
    // all four eligible while stalled: nothing moves
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i), GETM);
    bus_stall = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_all_ready: got %b expected %b", req_ready, 4'b0000); end
    @(posedge clk); #1;
    total++; if (bus_out !== 12'h000 || grant_cnt !== 16'd1 || dut.rr_ptr_q !== 2'd0) begin
      bad++; $display("FAIL stall_all_state: got bus=%h cnt=%0d ptr=%0d expected bus=000 cnt=1 ptr=0", bus_out, grant_cnt, dut.rr_ptr_q);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_wrap_and_counter();
    do_reset();
    set_req(2, 1'b1, 6'h02, GETM);
    @(posedge clk); #1;
    total++; if (dut.rr_ptr_q !== 2'd3) begin bad++; $display("FAIL wrap_ptr3: got %0d expected 3", dut.rr_ptr_q); end
    @(negedge clk);
    set_req(2, 1'b0, 6'h00, IDLE);
    set_req(3, 1'b1, 6'h13, GETS);
    set_req(0, 1'b1, 6'h20, PUTM);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready3: got %b expected %b", req_ready, 4'b1000); end
    @(posedge clk); #1;
    total++; if (bus_out !== msg(1'b1, 3'd3, 6'h13, GETS)) begin bad++; $display("FAIL wrap_bus3: got %h expected %h", bus_out, msg(1'b1, 3'd3, 6'h13, GETS)); end
    @(negedge clk);
    set_req(3, 1'b0, 6'h00, IDLE);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready0: got %b expected %b", req_ready, 4'b0001); end
    @(posedge clk); #1;
    total++; if (bus_out !== msg(1'b1, 3'd0, 6'h20, PUTM)) begin bad++; $display("FAIL wrap_bus0: got %h expected %h", bus_out, msg(1'b1, 3'd0, 6'h20, PUTM)); end
    // counter wrap: one grant per cycle for 65536 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i), GETS);
    repeat (65535) @(posedge clk);
    #1;
    total++; if (grant_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_max: got %h expected %h", grant_cnt, 16'hFFFF); end
    @(posedge clk); #1;
    total++; if (grant_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap: got %h expected %h", grant_cnt, 16'h0000); end
    total++; if (bus_out[11] !== 1'b1) begin bad++; $display("FAIL cnt_wrap_valid: got %b expected 1", bus_out[11]); end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 1'b1, 6'h2C, GETS);
    @(posedge clk); #1;
    total++; if (bus_out !== msg(1'b1, 3'd1, 6'h2C, GETS)) begin bad++; $display("FAIL areset_pre_bus: got %h expected %h", bus_out, msg(1'b1, 3'd1, 6'h2C, GETS)); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus_out !== 12'h000) begin bad++; $display("FAIL areset_bus: got %h expected %h", bus_out, 12'h000); end
    total++; if (grant_cnt !== 16'd0) begin bad++; $display("FAIL areset_cnt: got %0d expected 0", grant_cnt); end
    total++; if (dut.rr_ptr_q !== 2'd0) begin bad++; $display("FAIL areset_ptr: got %0d expected 0", dut.rr_ptr_q); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL areset_ready: got %b expected %b", req_ready, 4'b0000); end
    @(negedge clk);
    clear_reqs();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_idle_filter();
    test_stall();
    test_wrap_and_counter();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
